square_fixed_point: RTL
=======================

SQUARE_FIXED_POINT -- requirements
Module: square_fixed_point

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the bit width of root, rem and rad.
REQ-002 SHALL have parameter FBITS, default 0, the fractional bits of the fixed-point format; the legal range is 0 <= FBITS < WIDTH.
REQ-003 SHALL provide: clk  input  1  the only clock, rising edge.
REQ-004 SHALL provide: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide: start  input  1  loads operands and begins an operation.
REQ-006 SHALL provide: busy  output  1  an operation is in progress.
REQ-007 SHALL provide: valid  output  1  rad, ovf and inexact hold a finished result.
REQ-008 SHALL provide: root  input  WIDTH  the square root operand, with FBITS fractional bits.
REQ-009 SHALL provide: rem  input  WIDTH  the remainder operand, in the same scale as the square root block's rem.
REQ-010 SHALL provide: rad  output  WIDTH  the reconstructed radicand.
REQ-011 SHALL provide: ovf  output  1  the reconstructed radicand does not fit in WIDTH bits.
REQ-012 SHALL provide: inexact  output  1  the low FBITS bits of the full result are nonzero.
REQ-013 SHALL use one clock; reset is asynchronous and active-high.

Function
REQ-014 SHALL compute full = root*root + rem as an unsigned value of 2*WIDTH+1 bits.
- This inverts the team's fixed-point square root: rad*2^FBITS = root^2 + rem.
REQ-015 SHALL set rad = full[FBITS+WIDTH-1:FBITS].
REQ-016 SHALL set ovf = 1 iff any bit of full above FBITS+WIDTH-1 is 1.
REQ-017 SHALL set inexact = 1 iff full[FBITS-1:0] is nonzero; inexact is constant 0 when FBITS = 0.
REQ-018 SHALL use the FSM states IDLE, CALC and DONE.
REQ-019 SHALL compute by shift-add, one multiplier bit per cycle, LSB first.
- The accumulator is preloaded with rem.
- Root is added, shifted left by the bit index, whenever root bit i is 1.
- The block performs exactly WIDTH iterations.
REQ-020 SHALL capture root and rem on any rising edge where start = 1, enter CALC, set busy = 1 and clear valid.
REQ-021 SHALL, with start sampled at edge N, clear busy and set valid together at edge N+WIDTH, and load rad, ovf and inexact at that same edge (state DONE).
REQ-022 SHALL hold valid, rad, ovf and inexact stable in DONE until the next start or rst.
REQ-023 SHALL treat start during CALC as an abort and restart: new operands are captured, the iteration counter is zeroed and latency counts again from that edge.
REQ-024 SHALL give start in DONE the same response as start in IDLE.
REQ-025 SHALL ignore root and rem changes after capture.
REQ-026 SHALL keep the accumulator wide enough that the worst case (2^WIDTH-1)^2 + (2^WIDTH-1) never wraps.
REQ-027 SHALL keep rad, ovf and inexact unchanged while busy = 1; they still show the previous result.

Reset
REQ-028 SHALL on rst = 1 immediately force state IDLE, busy 0, valid 0, rad 0, ovf 0, inexact 0, and clear the accumulator and counter, regardless of clk.
REQ-029 SHALL abandon an operation in progress when rst is asserted, and not resume it.
REQ-030 SHALL ignore start while rst = 1; the first start after rst deasserts is handled normally.

Structure
REQ-031 SHALL place in a shared package square_fixed_point_pkg:
- the state enum (IDLE, CALC, DONE);
- a function for the iteration count, which equals WIDTH;
- a function for the accumulator width, which equals 2*WIDTH+1.
REQ-032 SHALL be a single module with no sub-module, holding the datapath and FSM together; the counter width is $clog2(WIDTH+1).

Verification
REQ-033 SHALL cover WIDTH=8, FBITS=0, root=15, rem=30: at start edge +8, rad=255, ovf=0, inexact=0, valid=1, busy=0.
REQ-034 SHALL cover WIDTH=8, FBITS=0, root=16, rem=0: rad=0, ovf=1.
REQ-035 SHALL cover WIDTH=8, FBITS=4, root=0x16, rem=28: rad=0x20, ovf=0, inexact=0; the same case with rem=29 gives rad=0x20, inexact=1.
REQ-036 SHALL cover restart: start with root=15, rem=30, then start with root=3, rem=1 four cycles later. Valid stays 0 until the second start edge +8, then rad=10.
REQ-037 SHALL cover reset mid-operation: rst pulse at the 5th CALC cycle gives busy=0, valid=0 and rad=0 asynchronously, with no valid afterward until a new start.
REQ-038 SHALL cover a randomized sweep over all root and rem values for WIDTH=8, FBITS in {0,4}, checked against a reference model of the full value.

Source files
------------

// File: rtl/square_fixed_point_pkg.sv
// Shared types and sizing helpers for the fixed-point squaring block.
package square_fixed_point_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    function automatic int iterCount(input int width);
        return width;
    endfunction

    // One spare bit over 2*WIDTH so root^2 + rem can never wrap.
    function automatic int accWidth(input int width);
        return 2 * width + 1;
    endfunction

endpackage

// File: rtl/square_fixed_point_if.sv
// Operand/result bundle between a requester and the squaring block.
interface square_fixed_point_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] root;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] rad;
    logic             ovf;
    logic             inexact;

    modport master (
        output start, root, rem,
        input  busy, valid, rad, ovf, inexact
    );

    modport slave (
        input  start, root, rem,
        output busy, valid, rad, ovf, inexact
    );
endinterface

// File: rtl/square_fixed_point.sv
// Rebuilds the radicand from a fixed-point root and remainder: rad*2^FBITS = root^2 + rem,
// using a serial shift-add multiply, one root bit per clock, LSB first.
module square_fixed_point
    import square_fixed_point_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FBITS = 0
) (
    input logic               clk,
    input logic               rst,
    square_fixed_point_if.slave bus
);

    localparam int ITER = iterCount(WIDTH);
    localparam int ACCW = accWidth(WIDTH);
    localparam int CNTW = $clog2(WIDTH + 1);
    localparam logic [ACCW-1:0] FRAC_MASK = (ACCW'(1) << FBITS) - ACCW'(1);

    state_e           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [ACCW-1:0]  acc_q, acc_d;
    logic [ACCW-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] rad_q, rad_d;
    logic             ovf_q, ovf_d;
    logic             inexact_q, inexact_d;

    logic [ACCW-1:0]  accSum;
    logic             lastIter;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rad_q     <= '0;
            ovf_q     <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            rad_q     <= rad_d;
            ovf_q     <= ovf_d;
            inexact_q <= inexact_d;
        end
    end

    // The multiplicand shifts left and the multiplier right, so bit i meets root << i.
    // Results are taken from the final sum directly so they land on the last CALC edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        rad_d     = rad_q;
        ovf_d     = ovf_q;
        inexact_d = inexact_q;

        accSum    = acc_q + (mplier_q[0] ? mcand_q : '0);
        lastIter  = (cnt_q == CNTW'(ITER - 1));

        if (bus.start) begin
            state_d  = CALC;
            cnt_d    = '0;
            acc_d    = ACCW'(bus.rem);
            mcand_d  = ACCW'(bus.root);
            mplier_d = bus.root;
        end else begin
            case (state_q)
                CALC: begin
                    acc_d    = accSum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNTW'(1);
                    if (lastIter) begin
                        state_d   = DONE;
                        rad_d     = WIDTH'(accSum >> FBITS);
                        ovf_d     = |(accSum >> (FBITS + WIDTH));
                        inexact_d = |(accSum & FRAC_MASK);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state_q == CALC);
    assign bus.valid   = (state_q == DONE);
    assign bus.rad     = rad_q;
    assign bus.ovf     = ovf_q;
    assign bus.inexact = inexact_q;

endmodule
